kernel_run_sequencer: RTL
=========================

Name: kernel_run_sequencer

Overview:
Batch controller that sequences the HLS kernel across all DATASET_NUM datasets preloaded in the kernel_ram banks. It sits between the VIO trigger and the kernel's start/done handshake, replacing the bare ap_start delay chain. It issues one start pulse per dataset and inserts a gap so the kernel_ram banks can swap datasets after each done. It counts output-stream writes and cycles per run, and reports errors and completion for probing.

Parameters:
DATASET_NUM, 8, number of kernel runs per batch
EXPECTED_OUT, 64, required y_out write count per run
START_DELAY, 4, idle cycles between k_done and the next k_start (0 allowed)
CNT_WIDTH, 32, width of cycle counters
TIMEOUT_CYCLES, 1048576, watchdog limit in RUN (used only with the macro)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous active-high reset
trig  in  1  batch trigger level, already in the ap_clk domain (VIO probe)
k_start  out  1  kernel start pulse
k_done  in  1  kernel done pulse
out_write  in  1  kernel output-stream write strobe
busy  out  1  batch in progress
batch_done  out  1  last batch finished (sticky until next batch)
cur_dataset  out  CLOG2(DATASET_NUM)  index of the run in progress or last run
run_cycles  out  CNT_WIDTH  latency of the most recent run
err_count  out  1  sticky: some run's write count was not EXPECTED_OUT
err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (async, effective immediately):
  - state IDLE; all outputs 0; trig_q 0; internal counters 0.
- FSM states: IDLE, START, RUN, GAP, DONE.
- IDLE:
  - On the trig rising edge (trig=1 and trig_q=0, trig_q registered every cycle), go to START.
  - On entry to START, clear cur_dataset, err_count, err_timeout, batch_done and the output counter.
- START:
  - Lasts exactly one cycle; k_start=1 only in this state (decoded from the state register).
  - Clear the cycle counter and the output counter; go to RUN.
- RUN:
  - Cycle counter increments each cycle, saturating at all-ones. The output counter increments on out_write.
  - When k_done is sampled high:
    - run_cycles = cycle count including this cycle. k_done high in the first RUN cycle gives run_cycles=1.
    - The final count includes an out_write in the same cycle. Set err_count if final count != EXPECTED_OUT. The output counter is CLOG2(EXPECTED_OUT)+2 bits wide and saturates.
    - If cur_dataset == DATASET_NUM-1, go to DONE. Otherwise increment cur_dataset and go to GAP.
- GAP:
  - Wait START_DELAY cycles, then go to START.
  - With START_DELAY=0, go from RUN directly to START.
- DONE:
  - busy=0, batch_done=1. Stay until trig==0, then go to IDLE; batch_done stays 1 in IDLE.
  - A trig held high never retriggers a batch.
- busy = 1 in START, RUN and GAP.
- Ignored inputs:
  - k_done outside RUN is ignored.
  - out_write outside RUN is ignored and not counted.
  - A trig edge while busy is ignored.
- cur_dataset never wraps within a batch. It holds its final value DATASET_NUM-1 until the next batch.

Optional Feature:
Macro KERNEL_RUN_SEQ_WATCHDOG_EN.
- Defined: in RUN, if the cycle count reaches TIMEOUT_CYCLES without k_done:
  - set err_timeout; run_cycles = TIMEOUT_CYCLES;
  - abort the batch and go to DONE (batch_done=1).
  - k_done and TIMEOUT_CYCLES reached in the same cycle is treated as done, with no timeout.
- Undefined: no watchdog logic; err_timeout is tied 0 and RUN waits indefinitely.

Test Plan:
1. Normal batch: DATASET_NUM=2, START_DELAY=4, kernel model raises k_done 10 cycles after k_start with 64 writes per run, trig 0->1 → exactly 2 one-cycle k_start pulses 15 cycles apart, run_cycles=10, cur_dataset=1, batch_done=1, err_count=0.
2. Count mismatch: 63 writes in run 0, 64 in run 1 → err_count=1 and the batch still completes. Also, 63 writes plus an out_write coincident with k_done → err_count=0.
3. Retrigger: trig held high after DONE → no new k_start. Then trig 1->0->1 → new batch, batch_done and err_count cleared on START.
4. Reset mid-RUN: assert ap_rst during run 1 → k_start, busy and batch_done are 0 immediately; a later trig edge restarts from cur_dataset=0.
5. Spurious inputs: k_done and out_write pulses in IDLE and GAP → no state change and no count change; START_DELAY=0 gives k_start one cycle after k_done.
6. Watchdog (macro on, TIMEOUT_CYCLES=100): k_done never asserted → err_timeout=1 and batch_done=1 after 100 RUN cycles, run_cycles=100. With the macro off → busy stays 1.

Source files
------------

// File: rtl/kernel_run_sequencer.sv
// Batch sequencer: one kernel start per dataset, a gap for bank swap, per-run write/cycle checks.
// Define KERNEL_RUN_SEQ_WATCHDOG_EN to abort a batch when a run exceeds TIMEOUT_CYCLES.
module kernel_run_sequencer #(
  parameter int DATASET_NUM    = 8,
  parameter int EXPECTED_OUT   = 64,
  parameter int START_DELAY    = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int DS_W = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 trig,
  output logic                 k_start,
  input  logic                 k_done,
  input  logic                 out_write,
  output logic                 busy,
  output logic                 batch_done,
  output logic [DS_W-1:0]      cur_dataset,
  output logic [CNT_WIDTH-1:0] run_cycles,
  output logic                 err_count,
  output logic                 err_timeout
);

  localparam int OC_W  = $clog2(EXPECTED_OUT) + 2;
  localparam int GAP_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DS_W-1:0]      DS_LAST     = DS_W'(DATASET_NUM - 1);
  localparam logic [OC_W-1:0]      OUT_EXP     = OC_W'(EXPECTED_OUT);
  localparam logic [GAP_W-1:0]     GAP_LAST    = GAP_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_GAP, S_DONE} state_t;

  state_t               state_q;
  logic                 trig_q;
  logic [DS_W-1:0]      cur_dataset_q;
  logic [CNT_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [OC_W-1:0]      out_cnt_q, out_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [CNT_WIDTH-1:0] run_cycles_q;
  logic                 err_count_q;
  logic                 batch_done_q;
  logic                 trig_rise;
  logic                 timeout_hit;

  // Both counters saturate; the _d values already include the current cycle / write.
  assign cyc_cnt_d = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
  assign out_cnt_d = (out_write && !(&out_cnt_q)) ? out_cnt_q + 1'b1 : out_cnt_q;
  assign trig_rise = trig && !trig_q;

`ifdef KERNEL_RUN_SEQ_WATCHDOG_EN
  logic err_timeout_q;

  // k_done in the limit cycle wins over the timeout.
  assign timeout_hit = (state_q == S_RUN) && !k_done && (cyc_cnt_d >= TIMEOUT_LIM);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err_timeout_q <= 1'b0;
    end else if (state_q == S_IDLE && trig_rise) begin
      err_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout_q <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_lim;

  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
  assign unused_timeout_lim = ^TIMEOUT_LIM;
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      trig_q        <= 1'b0;
      cur_dataset_q <= '0;
      cyc_cnt_q     <= '0;
      out_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      run_cycles_q  <= '0;
      err_count_q   <= 1'b0;
      batch_done_q  <= 1'b0;
    end else begin
      trig_q <= trig;
      case (state_q)
        S_IDLE: begin
          if (trig_rise) begin
            state_q       <= S_START;
            cur_dataset_q <= '0;
            err_count_q   <= 1'b0;
            batch_done_q  <= 1'b0;
            out_cnt_q     <= '0;
          end
        end
        S_START: begin
          cyc_cnt_q <= '0;
          out_cnt_q <= '0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          cyc_cnt_q <= cyc_cnt_d;
          out_cnt_q <= out_cnt_d;
          if (k_done) begin
            run_cycles_q <= cyc_cnt_d;
            if (out_cnt_d != OUT_EXP) begin
              err_count_q <= 1'b1;
            end
            if (cur_dataset_q == DS_LAST) begin
              state_q      <= S_DONE;
              batch_done_q <= 1'b1;
            end else begin
              cur_dataset_q <= cur_dataset_q + 1'b1;
              gap_cnt_q     <= '0;
              state_q       <= (START_DELAY == 0) ? S_START : S_GAP;
            end
          end else if (timeout_hit) begin
            run_cycles_q <= TIMEOUT_LIM;
            state_q      <= S_DONE;
            batch_done_q <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= S_START;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // Requiring trig low first means a held trigger cannot start another batch.
          if (!trig) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign k_start     = (state_q == S_START);
  assign busy        = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_GAP);
  assign batch_done  = batch_done_q;
  assign cur_dataset = cur_dataset_q;
  assign run_cycles  = run_cycles_q;
  assign err_count   = err_count_q;

endmodule
